// File: rtl/mem_arbiter.sv
// Two-port block-memory arbiter: serialises icache reads and dcache reads/writebacks
// onto one memory port, with round-robin on collision and a sticky hang detector.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 28,
   parameter int unsigned BLOCK_WIDTH    = 128,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   i_mem_read,
   input  logic [ADDR_WIDTH-1:0]  i_mem_address,
   output logic [BLOCK_WIDTH-1:0] i_mem_read_data,
   output logic                   i_mem_busywait,
   input  logic                   d_mem_read,
   input  logic                   d_mem_write,
   input  logic [ADDR_WIDTH-1:0]  d_mem_address,
   input  logic [BLOCK_WIDTH-1:0] d_mem_write_data,
   output logic [BLOCK_WIDTH-1:0] d_mem_read_data,
   output logic                   d_mem_busywait,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic [ADDR_WIDTH-1:0]  mem_address,
   output logic [BLOCK_WIDTH-1:0] mem_write_data,
   input  logic [BLOCK_WIDTH-1:0] mem_read_data,
   input  logic                   mem_busywait,
   output logic                   timeout_error
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   state_t                 state_q;
   logic                   last_grant_d_q;
   logic                   started_q;
   logic [15:0]            count_q;
   logic [15:0]            count_d;
   logic                   mem_read_q;
   logic                   mem_write_q;
   logic [ADDR_WIDTH-1:0]  mem_address_q;
   logic [BLOCK_WIDTH-1:0] mem_write_data_q;
   logic                   timeout_q;

   logic req_i;
   logic req_d;
   logic serving;
   logic done;
   logic grant_i;

   assign req_i   = i_mem_read;
   assign req_d   = d_mem_read | d_mem_write;
   assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);
   assign done    = serving & started_q & ~mem_busywait;
   // On collision the port that did not win last time gets the memory.
   assign grant_i = req_i & (~req_d | last_grant_d_q);
   assign count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         last_grant_d_q   <= 1'b1;
         started_q        <= 1'b0;
         count_q          <= '0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         mem_address_q    <= '0;
         mem_write_data_q <= '0;
         timeout_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_i || req_d) begin
                  mem_address_q  <= grant_i ? i_mem_address : d_mem_address;
                  // A simultaneous dcache read+write is treated as the writeback only.
                  mem_read_q     <= grant_i | ~d_mem_write;
                  mem_write_q    <= ~grant_i & d_mem_write;
                  if (!grant_i) begin
                     mem_write_data_q <= d_mem_write_data;
                  end
                  last_grant_d_q <= ~grant_i;
                  started_q      <= 1'b0;
                  count_q        <= '0;
                  state_q        <= grant_i ? SERVE_I : SERVE_D;
               end
            end
            SERVE_I, SERVE_D: begin
               count_q <= count_d;
               if (count_d >= TIMEOUT_LIMIT) begin
                  timeout_q <= 1'b1;
               end
               if (mem_busywait) begin
                  started_q <= 1'b1;
               end
               if (done) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  state_q     <= RELEASE;
               end
            end
            RELEASE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Busywait drops only in the done cycle so the cache fills on the returned block.
   assign i_mem_busywait  = req_i & ~((state_q == SERVE_I) & done);
   assign d_mem_busywait  = req_d & ~((state_q == SERVE_D) & done);
   assign i_mem_read_data = mem_read_data;
   assign d_mem_read_data = mem_read_data;

   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;
   assign timeout_error  = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized cache traffic
// checked against a transaction-order and memory-content reference model.
module tb_mem_arbiter;
   localparam int AW = 28;
   localparam int BW = 128;
   localparam int TO = 200;

   logic          clock = 1'b0;
   logic          reset;
   logic          i_mem_read;
   logic [AW-1:0] i_mem_address;
   logic [BW-1:0] i_mem_read_data;
   logic          i_mem_busywait;
   logic          d_mem_read;
   logic          d_mem_write;
   logic [AW-1:0] d_mem_address;
   logic [BW-1:0] d_mem_write_data;
   logic [BW-1:0] d_mem_read_data;
   logic          d_mem_busywait;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_write_data;
   logic [BW-1:0] mem_read_data;
   logic          mem_busywait;
   logic          timeout_error;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset),
      .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
      .i_mem_read_data(i_mem_read_data), .i_mem_busywait(i_mem_busywait),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
      .d_mem_write_data(d_mem_write_data), .d_mem_read_data(d_mem_read_data),
      .d_mem_busywait(d_mem_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .mem_busywait(mem_busywait), .timeout_error(timeout_error)
   );

   always #5 clock = ~clock;

   // Memory model: accepts a strobe, stays busy for 'lat' cycles (forever while 'hang').
   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [BW-1:0] wdata;
   } txn_t;

   logic [BW-1:0] mem_store [logic [AW-1:0]];
   logic [BW-1:0] ref_mem   [logic [AW-1:0]];
   txn_t          mlog[$];
   int            lat  = 3;
   bit            hang = 1'b0;

   function automatic logic [BW-1:0] init_blk(input logic [AW-1:0] a);
      logic [31:0] w;
      w = {4'h0, a};
      return {w ^ 32'h1111_0000, ~w, w, w ^ 32'hC0DE_0000};
   endfunction

   function automatic logic [BW-1:0] read_mem(input logic [AW-1:0] a);
      return mem_store.exists(a) ? mem_store[a] : init_blk(a);
   endfunction

   function automatic logic [BW-1:0] ref_read(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_blk(a);
   endfunction

   initial begin
      bit            m_active;
      bit            m_need_low;
      int            m_cnt;
      logic          m_is_write;
      logic [AW-1:0] m_addr;
      m_active = 0; m_need_low = 0; m_cnt = 0; m_is_write = 0; m_addr = '0;
      mem_busywait  = 1'b0;
      mem_read_data = '0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            m_active = 0; m_need_low = 0; mem_busywait = 1'b0;
         end else if (m_active) begin
            if (!hang) m_cnt--;
            if (m_cnt <= 0) begin
               mem_busywait = 1'b0;
               if (!m_is_write) mem_read_data = read_mem(m_addr);
               m_active = 0; m_need_low = 1;
            end
         end else if (m_need_low) begin
            if (!(mem_read || mem_write)) m_need_low = 0;
         end else if (mem_read || mem_write) begin
            m_active = 1; m_cnt = lat; mem_busywait = 1'b1;
            m_is_write = mem_write; m_addr = mem_address;
            if (mem_write) mem_store[mem_address] = mem_write_data;
            mlog.push_back(txn_t'{mem_write, mem_address, mem_write_data});
         end
      end
   end

   task automatic do_reset();
      i_mem_read = 0; i_mem_address = '0;
      d_mem_read = 0; d_mem_write = 0; d_mem_address = '0; d_mem_write_data = '0;
      hang = 0; reset = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1;
   endtask

   // Waits (bounded) for the selected requester's busywait to fall; not a checker.
   task automatic wait_fall(input bit is_d, output bit ok, output int n,
                            output bit other_any, output bit other_all);
      ok = 0; n = 0; other_any = 0; other_all = 1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clock); #1;
         if (!(is_d ? d_mem_busywait : i_mem_busywait)) begin
            ok = 1; n = k; break;
         end
         other_any = other_any | (is_d ? i_mem_busywait : d_mem_busywait);
         other_all = other_all & (is_d ? i_mem_busywait : d_mem_busywait);
      end
   endtask

   task automatic test_reset();
      i_mem_read = 0; i_mem_address = '0;
      d_mem_read = 0; d_mem_write = 0; d_mem_address = '0; d_mem_write_data = '0;
      reset = 0;
      repeat (2) @(posedge clock);
      #1;
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%b want=0", mem_read); end
      total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b want=0", mem_write); end
      total++; if (mem_address !== '0) begin bad++; $display("FAIL reset_mem_address got=%h want=0", mem_address); end
      total++; if (mem_write_data !== '0) begin bad++; $display("FAIL reset_mem_write_data got=%h want=0", mem_write_data); end
      total++; if (timeout_error !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout_error); end
      total++; if (i_mem_busywait !== 1'b0 || d_mem_busywait !== 1'b0) begin
         bad++; $display("FAIL reset_busywait got i=%b d=%b want 0 0", i_mem_busywait, d_mem_busywait); end
      @(posedge clock); #1 reset = 1;
   endtask

   task automatic test_icache_only();
      bit ok, oany, oall; int n;
      lat = 5;
      @(posedge clock); #1;
      i_mem_read = 1; i_mem_address = 28'h0000010;
      #1;
      total++; if (i_mem_busywait !== 1'b1 || mem_read !== 1'b0) begin
         bad++; $display("FAIL ionly_first_cycle got busy=%b strobe=%b want 1 0", i_mem_busywait, mem_read); end
      @(posedge clock); #1;
      total++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 28'h0000010) begin
         bad++; $display("FAIL ionly_strobe got rd=%b wr=%b addr=%h want 1 0 0000010", mem_read, mem_write, mem_address); end
      wait_fall(0, ok, n, oany, oall);
      total++; if (!ok || n != lat) begin bad++; $display("FAIL ionly_done got ok=%0b cycles=%0d want 1 %0d", ok, n, lat); end
      total++; if (i_mem_read_data !== init_blk(28'h10) || d_mem_read_data !== init_blk(28'h10)) begin
         bad++; $display("FAIL ionly_data got=%h want=%h", i_mem_read_data, init_blk(28'h10)); end
      total++; if (oany !== 1'b0 || d_mem_busywait !== 1'b0) begin bad++; $display("FAIL ionly_d_busy got=%b want=0", oany); end
      @(posedge clock); #1;
      i_mem_read = 0;
      total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         bad++; $display("FAIL ionly_release got rd=%b wr=%b want 0 0", mem_read, mem_write); end
      @(posedge clock); #1;
   endtask

   task automatic test_simultaneous();
      bit ok, oany, oall; int n;
      do_reset();
      lat = 3;
      @(posedge clock); #1;
      i_mem_read = 1; i_mem_address = 28'h1;
      d_mem_read = 1; d_mem_address = 28'h2;
      @(posedge clock); #1;
      total++; if (mem_read !== 1'b1 || mem_address !== 28'h1) begin
         bad++; $display("FAIL simul_first got rd=%b addr=%h want 1 0000001", mem_read, mem_address); end
      wait_fall(0, ok, n, oany, oall);
      total++; if (!ok || oall !== 1'b1 || d_mem_busywait !== 1'b1) begin
         bad++; $display("FAIL simul_d_held got ok=%0b all=%b now=%b want 1 1 1", ok, oall, d_mem_busywait); end
      @(posedge clock); #1;
      i_mem_read = 0;
      total++; if (mem_read !== 1'b0 || d_mem_busywait !== 1'b1) begin
         bad++; $display("FAIL simul_release got rd=%b dbusy=%b want 0 1", mem_read, d_mem_busywait); end
      @(posedge clock); #1;
      total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL simul_idle got rd=%b want 0", mem_read); end
      @(posedge clock); #1;
      total++; if (mem_read !== 1'b1 || mem_address !== 28'h2) begin
         bad++; $display("FAIL simul_second got rd=%b addr=%h want 1 0000002", mem_read, mem_address); end
      wait_fall(1, ok, n, oany, oall);
      total++; if (!ok || d_mem_read_data !== init_blk(28'h2)) begin
         bad++; $display("FAIL simul_d_data got=%h want=%h", d_mem_read_data, init_blk(28'h2)); end
      @(posedge clock); #1;
      d_mem_read = 0;
      @(posedge clock); #1;
   endtask

   task automatic test_dirty_miss();
      bit ok, oany, oall, stable; int n, n0;
      logic [BW-1:0] wd;
      wd = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      lat = 4;
      n0 = mlog.size();
      @(posedge clock); #1;
      d_mem_write = 1; d_mem_address = 28'h30; d_mem_write_data = wd;
      @(posedge clock); #1;
      i_mem_read = 1; i_mem_address = 28'h40;
      stable = (mem_write === 1'b1) && (mem_write_data === wd);
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clock); #1;
         if (!d_mem_busywait) begin ok = 1; break; end
         stable = stable && (mem_write === 1'b1) && (mem_write_data === wd) && (mem_read === 1'b0);
      end
      total++; if (!ok || !stable) begin bad++; $display("FAIL dirty_write_stable got ok=%0b stable=%0b want 1 1", ok, stable); end
      @(posedge clock); #1;
      d_mem_write = 0; d_mem_read = 1; d_mem_address = 28'h31;
      wait_fall(0, ok, n, oany, oall);
      total++; if (!ok || i_mem_read_data !== init_blk(28'h40) || oall !== 1'b1) begin
         bad++; $display("FAIL dirty_i_between got ok=%0b data=%h dheld=%b want=%h", ok, i_mem_read_data, oall, init_blk(28'h40)); end
      @(posedge clock); #1;
      i_mem_read = 0;
      wait_fall(1, ok, n, oany, oall);
      total++; if (!ok || d_mem_read_data !== init_blk(28'h31)) begin
         bad++; $display("FAIL dirty_fill got ok=%0b data=%h want=%h", ok, d_mem_read_data, init_blk(28'h31)); end
      @(posedge clock); #1;
      d_mem_read = 0;
      total++;
      if (mlog.size() != n0 + 3) begin
         bad++; $display("FAIL dirty_order got count=%0d want=%0d", mlog.size() - n0, 3);
      end else if (!(mlog[n0].wr === 1'b1 && mlog[n0].addr === 28'h30 && mlog[n0].wdata === wd &&
                     mlog[n0+1].wr === 1'b0 && mlog[n0+1].addr === 28'h40 &&
                     mlog[n0+2].wr === 1'b0 && mlog[n0+2].addr === 28'h31)) begin
         bad++; $display("FAIL dirty_order got %0b:%h %0b:%h %0b:%h want 1:30 0:40 0:31",
            mlog[n0].wr, mlog[n0].addr, mlog[n0+1].wr, mlog[n0+1].addr, mlog[n0+2].wr, mlog[n0+2].addr);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_both_rw();
      bit ok, oany, oall, no_rd; int n;
      logic [BW-1:0] wd;
      wd = {$urandom, $urandom, $urandom, $urandom};
      lat = 2;
      @(posedge clock); #1;
      d_mem_read = 1; d_mem_write = 1; d_mem_address = 28'h55; d_mem_write_data = wd;
      @(posedge clock); #1;
      total++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_write_data !== wd) begin
         bad++; $display("FAIL rw_write_wins got rd=%b wr=%b data=%h want 0 1 %h", mem_read, mem_write, mem_write_data, wd); end
      no_rd = 1;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clock); #1;
         if (!d_mem_busywait) begin ok = 1; break; end
         no_rd = no_rd && (mem_read === 1'b0);
      end
      total++; if (!ok || !no_rd || mlog[$].wr !== 1'b1 || mlog[$].addr !== 28'h55) begin
         bad++; $display("FAIL rw_only_write got ok=%0b nord=%0b logwr=%b want 1 1 1", ok, no_rd, mlog[$].wr); end
      @(posedge clock); #1;
      d_mem_read = 0; d_mem_write = 0;
      @(posedge clock); #1;
   endtask

   task automatic test_reset_mid();
      bit ok, oany, oall; int n;
      lat = 6;
      @(posedge clock); #1;
      d_mem_read = 1; d_mem_address = 28'h77;
      @(posedge clock); #1;
      total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL rmid_serving got rd=%b want 1", mem_read); end
      @(posedge clock); #2;
      reset = 0;
      #1;
      total++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== '0) begin
         bad++; $display("FAIL rmid_async got rd=%b wr=%b addr=%h want 0 0 0", mem_read, mem_write, mem_address); end
      @(posedge clock); #2;
      reset = 1;
      @(posedge clock); #1;
      total++; if (mem_read !== 1'b1 || mem_address !== 28'h77) begin
         bad++; $display("FAIL rmid_regrant got rd=%b addr=%h want 1 0000077", mem_read, mem_address); end
      wait_fall(1, ok, n, oany, oall);
      total++; if (!ok || n != lat || d_mem_read_data !== init_blk(28'h77)) begin
         bad++; $display("FAIL rmid_complete got ok=%0b cycles=%0d data=%h want %0d %h", ok, n, d_mem_read_data, lat, init_blk(28'h77)); end
      @(posedge clock); #1;
      d_mem_read = 0;
      @(posedge clock); #1;
   endtask

   task automatic test_timeout();
      bit ok, oany, oall; int n;
      lat = 2; hang = 1;
      @(posedge clock); #1;
      i_mem_read = 1; i_mem_address = 28'h99;
      @(posedge clock); #1;
      total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL tmo_strobe got rd=%b want 1", mem_read); end
      repeat (TO - 1) @(posedge clock);
      #1;
      total++; if (timeout_error !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b want=0 at cycle %0d", timeout_error, TO - 1); end
      @(posedge clock); #1;
      total++; if (timeout_error !== 1'b1 || mem_read !== 1'b1 || i_mem_busywait !== 1'b1) begin
         bad++; $display("FAIL tmo_raise got err=%b rd=%b busy=%b want 1 1 1", timeout_error, mem_read, i_mem_busywait); end
      hang = 0;
      wait_fall(0, ok, n, oany, oall);
      total++; if (!ok || i_mem_read_data !== init_blk(28'h99)) begin
         bad++; $display("FAIL tmo_completes got ok=%0b data=%h want=%h", ok, i_mem_read_data, init_blk(28'h99)); end
      @(posedge clock); #1;
      i_mem_read = 0;
      repeat (3) @(posedge clock);
      #1;
      total++; if (timeout_error !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b want=1", timeout_error); end
      do_reset();
      total++; if (timeout_error !== 1'b0) begin bad++; $display("FAIL tmo_cleared got=%b want=0", timeout_error); end
   endtask

   task automatic test_random();
      localparam int N = 25;
      bit            req[2];
      bit            snap[2];
      int            gap[2];
      int            ndone[2];
      int            nissued[2];
      logic [AW-1:0] c_addr[2];
      logic [BW-1:0] exp_rd[2];
      bit            c_rd, c_wr, busy_p, exp_wr;
      logic [BW-1:0] c_wdata, got;
      int            last_ref, cur, seen, gp, r;
      txn_t          t;
      do_reset();
      for (int p = 0; p < 2; p++) begin
         req[p] = 0; snap[p] = 0; gap[p] = 0; ndone[p] = 0; nissued[p] = 0;
         c_addr[p] = '0; exp_rd[p] = '0;
      end
      c_rd = 0; c_wr = 0; c_wdata = '0;
      last_ref = 1; cur = -1; seen = mlog.size();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clock); #4;
         while (mlog.size() > seen) begin
            t = mlog[seen]; seen++;
            if (snap[0] && snap[1]) gp = (last_ref == 1) ? 0 : 1;
            else if (snap[0]) gp = 0;
            else if (snap[1]) gp = 1;
            else gp = -1;
            total++;
            if (gp < 0) begin
               bad++; $display("FAIL rand_grant got addr=%h want no transfer", t.addr);
            end else begin
               exp_wr = (gp == 1) && c_wr;
               if (t.wr !== exp_wr || t.addr !== c_addr[gp] || (exp_wr && t.wdata !== c_wdata)) begin
                  bad++; $display("FAIL rand_grant got wr=%b addr=%h want port=%0d wr=%b addr=%h", t.wr, t.addr, gp, exp_wr, c_addr[gp]);
               end
               last_ref = gp; cur = gp;
               if (exp_wr) ref_mem[c_addr[gp]] = c_wdata;
               else exp_rd[gp] = ref_read(c_addr[gp]);
            end
         end
         snap[0] = req[0]; snap[1] = req[1];
         for (int p = 0; p < 2; p++) begin
            if (req[p]) begin
               busy_p = (p == 0) ? i_mem_busywait : d_mem_busywait;
               if (!busy_p) begin
                  got = (p == 0) ? i_mem_read_data : d_mem_read_data;
                  total++;
                  if (cur != p || (!(p == 1 && c_wr) && got !== exp_rd[p])) begin
                     bad++; $display("FAIL rand_complete port=%0d got owner=%0d data=%h want data=%h", p, cur, got, exp_rd[p]);
                  end
                  cur = -1; req[p] = 0; ndone[p]++; gap[p] = $urandom_range(0, 3);
               end
            end
         end
         if (ndone[0] == N && ndone[1] == N) break;
         @(posedge clock); #1;
         lat = $urandom_range(1, 4);
         for (int p = 0; p < 2; p++) begin
            if (!req[p]) begin
               if (gap[p] > 0) gap[p]--;
               else if (nissued[p] < N) begin
                  req[p] = 1; nissued[p]++;
                  c_addr[p] = 28'h100 + 28'($urandom_range(0, 7));
                  if (p == 1) begin
                     r = $urandom_range(0, 3);
                     c_rd = (r != 2); c_wr = (r >= 2);
                     c_wdata = {$urandom, $urandom, $urandom, $urandom};
                  end
               end
            end
         end
         i_mem_read = req[0]; i_mem_address = c_addr[0];
         d_mem_read = req[1] & c_rd; d_mem_write = req[1] & c_wr;
         d_mem_address = c_addr[1]; d_mem_write_data = c_wdata;
      end
      @(posedge clock); #1;
      i_mem_read = 0; d_mem_read = 0; d_mem_write = 0;
      total++; if (ndone[0] != N || ndone[1] != N) begin
         bad++; $display("FAIL rand_drain got i=%0d d=%0d want %0d each", ndone[0], ndone[1], N); end
   endtask

   initial begin
      test_reset();
      test_icache_only();
      test_simultaneous();
      test_dirty_miss();
      test_both_rw();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
